// File: rtl/rc_servo_pulse_gen_if.sv
// Position/pulse bundle between the tracking core (master) and one servo axis generator (slave).
interface rc_servo_pulse_gen_if;
    logic [7:0] pos_i;
    logic       pos_valid_i;
    logic       pwm_o;
    logic       frame_start_o;
    logic [7:0] active_pos_o;
    logic       upd_pending_o;

    modport master (
        output pos_i, pos_valid_i,
        input  pwm_o, frame_start_o, active_pos_o, upd_pending_o
    );

    modport slave (
        input  pos_i, pos_valid_i,
        output pwm_o, frame_start_o, active_pos_o, upd_pending_o
    );
endinterface

// File: rtl/rc_servo_pulse_gen.sv
// RC servo frame generator with frame-boundary double-buffered position.
// Optional per-frame slew limiting is enabled by defining RC_SERVO_SLEW_LIMIT_EN.
module rc_servo_pulse_gen #(
    parameter int unsigned TICK_DIV    = 50,
    parameter int unsigned FRAME_TICKS = 20000,
    parameter int unsigned MIN_TICKS   = 1000,
    parameter int unsigned RESET_POS   = 128,
    parameter int unsigned SLEW_STEP   = 4
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    rc_servo_pulse_gen_if.slave  bus
);
    localparam int unsigned DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(TICK_DIV - 1);
    localparam logic [15:0]      FRAME_LAST = 16'(FRAME_TICKS - 1);
    localparam logic [15:0]      MIN_W      = 16'(MIN_TICKS);
    localparam logic [7:0]       POS_RST    = 8'(RESET_POS);
    localparam logic [7:0]       STEP       = 8'(SLEW_STEP);

    if (TICK_DIV < 1 || MIN_TICKS + 1020 >= FRAME_TICKS || FRAME_TICKS > 65536 ||
        RESET_POS > 255 || SLEW_STEP < 1 || SLEW_STEP > 255) begin : g_param_check
        $error("rc_servo_pulse_gen: illegal parameter combination");
    end

    typedef enum logic [1:0] {ST_START, ST_HIGH, ST_LOW} state_e;

    state_e           state_q;
    logic [DIV_W-1:0] div_cnt_q;
    logic [15:0]      frame_cnt_q;
    logic [7:0]       pending_pos_q;
    logic [7:0]       active_pos_q;
    logic [7:0]       active_pos_d;
    logic             upd_pending_q;
    logic             pwm_q;
    logic             frame_start_q;

    logic        tick;
    logic        boundary;
    logic [15:0] width;

    assign tick     = (div_cnt_q == DIV_LAST);
    assign boundary = (state_q == ST_START) || (tick && frame_cnt_q == FRAME_LAST);
    assign width    = MIN_W + {6'd0, active_pos_q, 2'b00};

    // Position adopted at the next frame boundary, taken from the pending value before the edge.
    always_comb begin
        active_pos_d = pending_pos_q;
`ifdef RC_SERVO_SLEW_LIMIT_EN
        if (pending_pos_q > active_pos_q) begin
            if (pending_pos_q - active_pos_q > STEP) active_pos_d = active_pos_q + STEP;
        end else if (active_pos_q - pending_pos_q > STEP) begin
            active_pos_d = active_pos_q - STEP;
        end
`endif
    end

    // NOTE: all state here is assigned with <= so every right-hand side sees pre-edge values.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q       <= ST_START;
            div_cnt_q     <= '0;
            frame_cnt_q   <= '0;
            pending_pos_q <= POS_RST;
            active_pos_q  <= POS_RST;
            upd_pending_q <= 1'b0;
            pwm_q         <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            frame_start_q <= 1'b0;
            if (bus.pos_valid_i) begin
                pending_pos_q <= bus.pos_i;
                upd_pending_q <= 1'b1;
            end
            if (boundary) begin
                state_q       <= ST_HIGH;
                div_cnt_q     <= '0;
                frame_cnt_q   <= '0;
                pwm_q         <= 1'b1;
                frame_start_q <= 1'b1;
                active_pos_q  <= active_pos_d;
                upd_pending_q <= bus.pos_valid_i || (active_pos_d != pending_pos_q);
            end else if (tick) begin
                div_cnt_q   <= '0;
                frame_cnt_q <= frame_cnt_q + 16'd1;
                if (state_q == ST_HIGH && frame_cnt_q == width - 16'd1) begin
                    pwm_q   <= 1'b0;
                    state_q <= ST_LOW;
                end
            end else begin
                div_cnt_q <= div_cnt_q + DIV_W'(1);
            end
        end
    end

    assign bus.pwm_o         = pwm_q;
    assign bus.frame_start_o = frame_start_q;
    assign bus.active_pos_o  = active_pos_q;
    assign bus.upd_pending_o = upd_pending_q;
endmodule

// File: tb/tb_rc_servo_pulse_gen.sv
// Bench for rc_servo_pulse_gen: frame-time reference model checked every cycle plus directed scenarios.
// Build with RC_SERVO_SLEW_LIMIT_EN defined to exercise the slew-limited variant.
module tb_rc_servo_pulse_gen;
    localparam int FRAME = 3000;
    localparam int STEP  = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rc_servo_pulse_gen_if bus_if ();

    rc_servo_pulse_gen #(
        .TICK_DIV(1), .FRAME_TICKS(FRAME), .MIN_TICKS(1000), .RESET_POS(128), .SLEW_STEP(STEP)
    ) dut (
        .clk_i  (clk),
        .reset_i(rst),
        .bus    (bus_if.slave)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input int exp);
        n_cmp++;
        if (act !== 32'(exp)) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: time elapsed since the current frame began, and the positions it uses.
    int m_t       = 0;
    bit m_started = 0;
    int m_active  = 128;
    int m_pending = 128;
    bit m_upd     = 0;
    bit m_ready   = 0;

    function automatic int next_active(input int act, input int pend);
`ifdef RC_SERVO_SLEW_LIMIT_EN
        if (pend > act) return (pend - act > STEP) ? act + STEP : pend;
        return (act - pend > STEP) ? act - STEP : pend;
`else
        return pend;
`endif
    endfunction

    always @(posedge clk) begin
        int a;
        if (rst) begin
            m_started <= 0; m_t <= 0; m_active <= 128; m_pending <= 128; m_upd <= 0; m_ready <= 1;
        end else if (m_ready) begin
            if (!m_started || m_t == FRAME - 1) begin
                a = next_active(m_active, m_pending);
                m_started <= 1;
                m_t       <= 0;
                m_active  <= a;
                m_upd     <= bus_if.pos_valid_i || (a != m_pending);
            end else begin
                m_t <= m_t + 1;
                if (bus_if.pos_valid_i) m_upd <= 1;
            end
            if (bus_if.pos_valid_i) m_pending <= int'(bus_if.pos_i);
        end
    end

    always @(negedge clk) begin
        if (m_ready) begin
            check("pwm",         bus_if.pwm_o,         int'(m_started && m_t < 1000 + 4 * m_active));
            check("frame_start", bus_if.frame_start_o, int'(m_started && m_t == 0));
            check("active_pos",  bus_if.active_pos_o,  m_active);
            check("upd_pending", bus_if.upd_pending_o, int'(m_upd));
        end
    end

    // Measures high time and period of each completed frame.
    int hc = 0, pc = 0, last_high = -1, last_period = -1;
    bit have = 0;
    always @(negedge clk) begin
        if (rst) begin
            have <= 0; last_high <= -1; last_period <= -1;
        end else if (bus_if.frame_start_o) begin
            if (have) begin
                last_high   <= hc;
                last_period <= pc;
            end
            hc   <= int'(bus_if.pwm_o);
            pc   <= 1;
            have <= 1;
        end else if (have) begin
            hc <= hc + int'(bus_if.pwm_o);
            pc <= pc + 1;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic wait_fs(input string name);
        for (int i = 0; i < FRAME + 10; i++) begin
            step(1);
            if (bus_if.frame_start_o === 1'b1) return;
        end
        n_cmp++;
        n_bad++;
        $display("FAIL %s: frame_start timeout, got none, expected one within %0d clocks", name, FRAME + 10);
    endtask

    task automatic strobe(input logic [7:0] v);
        bus_if.pos_i       = v;
        bus_if.pos_valid_i = 1'b1;
        step(1);
        bus_if.pos_valid_i = 1'b0;
    endtask

    initial begin
        bus_if.pos_i       = 8'd0;
        bus_if.pos_valid_i = 1'b0;
        rst                = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_pwm", bus_if.pwm_o, 0);
        check("rst_fs", bus_if.frame_start_o, 0);
        check("rst_active", bus_if.active_pos_o, 128);
        check("rst_upd", bus_if.upd_pending_o, 0);
        #1 rst = 1'b0;
        step(1);
        check("first_fs", bus_if.frame_start_o, 1);
        check("first_pwm", bus_if.pwm_o, 1);

        wait_fs("idle");
        check("idle_high", last_high, 1512);
        check("idle_period", last_period, FRAME);
        check("idle_active", bus_if.active_pos_o, 128);

`ifndef RC_SERVO_SLEW_LIMIT_EN
        step(100);
        strobe(8'd0);
        check("s2_upd_set", bus_if.upd_pending_o, 1);
        wait_fs("s2a");
        check("s2_cur_high", last_high, 1512);
        check("s2_active", bus_if.active_pos_o, 0);
        check("s2_upd_clr", bus_if.upd_pending_o, 0);
        wait_fs("s2b");
        check("s2_next_high", last_high, 1000);

        step(50);
        strobe(8'h10);
        step(10);
        strobe(8'hFF);
        wait_fs("s3a");
        check("s3_active", bus_if.active_pos_o, 255);
        wait_fs("s3b");
        check("s3_high", last_high, 2020);

        step(FRAME - 1);
        bus_if.pos_i       = 8'd0;
        bus_if.pos_valid_i = 1'b1;
        wait_fs("s4a");
        bus_if.pos_valid_i = 1'b0;
        check("s4_keep_active", bus_if.active_pos_o, 255);
        check("s4_upd_held", bus_if.upd_pending_o, 1);
        wait_fs("s4b");
        check("s4_old_high", last_high, 2020);
        check("s4_active", bus_if.active_pos_o, 0);
        check("s4_upd_clr", bus_if.upd_pending_o, 0);
        wait_fs("s4c");
        check("s4_new_high", last_high, 1000);
`endif

        step(499);
        check("s5_pwm_before", bus_if.pwm_o, 1);
        rst = 1'b1;
        step(1);
        check("s5_abort_pwm", bus_if.pwm_o, 0);
        check("s5_abort_active", bus_if.active_pos_o, 128);
        step(1);
        rst = 1'b0;
        wait_fs("s5a");
        check("s5_restart_pwm", bus_if.pwm_o, 1);
        wait_fs("s5b");
        check("s5_high", last_high, 1512);
        check("s5_period", last_period, FRAME);

`ifdef RC_SERVO_SLEW_LIMIT_EN
        step(200);
        strobe(8'd140);
        wait_fs("slew1");
        check("slew_132", bus_if.active_pos_o, 132);
        check("slew_upd1", bus_if.upd_pending_o, 1);
        wait_fs("slew2");
        check("slew_136", bus_if.active_pos_o, 136);
        check("slew_upd2", bus_if.upd_pending_o, 1);
        wait_fs("slew3");
        check("slew_140", bus_if.active_pos_o, 140);
        check("slew_upd3", bus_if.upd_pending_o, 0);
        wait_fs("slew4");
        check("slew_high", last_high, 1560);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
